game_round_controller: RTL and testbench

- Sequential game-flow controller for the battleship CPLD design.
- Sits directly upstream of the battleship display/hit-map top level and drives its 2-bit game_state_code.
- Consumes the per-cell hit/miss result that the top level produces for the addressed coordinate.
- Counts shots and hits, issues a single-cycle attack strobe per valid confirmed shot, and decides win/lose.

---
 rtl/game_round_controller.sv | 174 +++++++++++++++++
 tb/tb_game_round_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/game_round_controller.sv
// Battleship round flow: IDLE/PREP/ATTACK/END, shot/hit counting, win/lose.
// Build option HIT_REFUND_EN: hits do not consume a shot.
module game_round_controller #(
  parameter int unsigned MAX_SHOTS = 12,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_n,
  input  logic             confirm_n,
  input  logic             coord_valid,
  input  logic             cell_is_ship,
  input  logic             cell_already_hit,
  input  logic [CNT_W-1:0] ship_total,
  output logic [1:0]       game_state_code,
  output logic             attack_strobe,
  output logic             shot_hit,
  output logic             dup_shot,
  output logic [CNT_W-1:0] shots_left,
  output logic [CNT_W-1:0] hits_count,
  output logic             win,
  output logic             lose
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_ATK  = 2'b10,
    S_END  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_SHOTS);
  localparam logic [CNT_W-1:0] SAT_L = '1;

  state_t           state_q, state_d;
  logic             start_prev_q, conf_prev_q;
  logic             pend_q, pend_d;
  logic             pend_ok_q, pend_ok_d;
  logic             pend_ship_q, pend_ship_d;
  logic             strobe_q, strobe_d;
  logic             hit_q, hit_d;
  logic             dup_q, dup_d;
  logic [CNT_W-1:0] shots_q, shots_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic             start_press, conf_press;
  logic             consume;

  assign start_press = start_prev_q & ~start_n;
  assign conf_press  = conf_prev_q & ~confirm_n;

  // Whether the resolving shot uses up one of the remaining shots
  always_comb begin
    consume = 1'b1;
`ifdef HIT_REFUND_EN
    consume = ~pend_ship_q;
`else
    consume = 1'b1;
`endif
  end

  // Next-state: a press is captured, then resolved one edge later
  always_comb begin
    state_d     = state_q;
    pend_d      = 1'b0;
    pend_ok_d   = pend_ok_q;
    pend_ship_d = pend_ship_q;
    strobe_d    = 1'b0;
    hit_d       = hit_q;
    dup_d       = 1'b0;
    shots_d     = shots_q;
    hits_d      = hits_q;
    win_d       = win_q;
    lose_d      = lose_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_press) begin
          state_d = S_PREP;
          shots_d = '0;
          hits_d  = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
        end
      end
      S_PREP: begin
        if (start_press) begin
          state_d = S_ATK;
          shots_d = MAX_L;
          hits_d  = '0;
        end
      end
      S_ATK: begin
        if (conf_press) begin
          pend_d      = 1'b1;
          pend_ok_d   = coord_valid & ~cell_already_hit;
          pend_ship_d = cell_is_ship;
        end
        if (pend_q) begin
          if (pend_ok_q) begin
            strobe_d = 1'b1;
            hit_d    = pend_ship_q;
            if (pend_ship_q && hits_q != SAT_L)
              hits_d = hits_q + 1'b1;
            if (consume && shots_q != '0)
              shots_d = shots_q - 1'b1;
          end else begin
            dup_d = 1'b1;
          end
        end
        if (hits_d >= ship_total) begin
          state_d = S_END;
          win_d   = 1'b1;
        end else if (shots_d == '0) begin
          state_d = S_END;
          lose_d  = 1'b1;
        end
      end
      S_END: begin
        if (start_press) begin
          state_d = S_IDLE;
          shots_d = '0;
          hits_d  = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight shot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b1;
      conf_prev_q  <= 1'b1;
      pend_q       <= 1'b0;
      pend_ok_q    <= 1'b0;
      pend_ship_q  <= 1'b0;
      strobe_q     <= 1'b0;
      hit_q        <= 1'b0;
      dup_q        <= 1'b0;
      shots_q      <= '0;
      hits_q       <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_n;
      conf_prev_q  <= confirm_n;
      pend_q       <= pend_d;
      pend_ok_q    <= pend_ok_d;
      pend_ship_q  <= pend_ship_d;
      strobe_q     <= strobe_d;
      hit_q        <= hit_d;
      dup_q        <= dup_d;
      shots_q      <= shots_d;
      hits_q       <= hits_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  assign game_state_code = state_q;
  assign attack_strobe   = strobe_q;
  assign shot_hit        = hit_q;
  assign dup_shot        = dup_q;
  assign shots_left      = shots_q;
  assign hits_count      = hits_q;
  assign win             = win_q;
  assign lose            = lose_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench for game_round_controller.
// Honours HIT_REFUND_EN when defined.
module tb_game_round_controller;

`ifdef HIT_REFUND_EN
  localparam bit REF = 1'b1;
`else
  localparam bit REF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_n = 1'b1;
  logic       confirm_n = 1'b1;
  logic       coord_valid = 1'b1;
  logic       cell_is_ship = 1'b0;
  logic       cell_already_hit = 1'b0;
  logic [3:0] ship_total = 4'd3;
  logic [1:0] game_state_code;
  logic       attack_strobe, shot_hit, dup_shot;
  logic [3:0] shots_left, hits_count;
  logic       win, lose;

  game_round_controller #(.MAX_SHOTS(12), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .start_n(start_n),
    .confirm_n(confirm_n),
    .coord_valid(coord_valid),
    .cell_is_ship(cell_is_ship),
    .cell_already_hit(cell_already_hit),
    .ship_total(ship_total),
    .game_state_code(game_state_code),
    .attack_strobe(attack_strobe),
    .shot_hit(shot_hit),
    .dup_shot(dup_shot),
    .shots_left(shots_left),
    .hits_count(hits_count),
    .win(win),
    .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit is_dup;
    bit hit;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every strobe/dup cycle must match the next expected event
  always @(negedge clk) begin
    if (attack_strobe || dup_shot) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: strobe=%0b dup=%0b expected none",
                 attack_strobe, dup_shot);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (attack_strobe !== !e.is_dup || dup_shot !== e.is_dup ||
            (!e.is_dup && shot_hit !== e.hit)) begin
          errors++;
          $display("FAIL event: strobe=%0b dup=%0b hit=%0b expected dup=%0b hit=%0b",
                   attack_strobe, dup_shot, shot_hit, e.is_dup, e.hit);
        end
      end
    end
  end

  task automatic press_start();
    @(negedge clk);
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
  endtask

  task automatic shoot(input bit v, input bit s, input bit a);
    ev_t e;
    @(negedge clk);
    coord_valid      = v;
    cell_is_ship     = s;
    cell_already_hit = a;
    confirm_n        = 1'b0;
    e.is_dup = !(v && !a);
    e.hit    = s;
    exp_q.push_back(e);
    @(negedge clk);
    confirm_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_state(input string nm, input logic [1:0] st,
                           input logic [3:0] sl, input logic [3:0] hc,
                           input bit w, input bit l);
    chk({nm, "_state"}, 32'(game_state_code), 32'(st));
    chk({nm, "_shots"}, 32'(shots_left), 32'(sl));
    chk({nm, "_hits"}, 32'(hits_count), 32'(hc));
    chk({nm, "_win"}, 32'(win), 32'(w));
    chk({nm, "_lose"}, 32'(lose), 32'(l));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ns;
    repeat (3) @(negedge clk);
    chk_state("reset", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("reset_strobe", 32'(attack_strobe), 32'd0);
    chk("reset_dup", 32'(dup_shot), 32'd0);
    reset = 1'b1;

    // Round 1: enter ATTACK, rejected presses, then win with 3 ships
    ship_total = 4'd3;
    press_start();
    chk_state("prep", 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    shoot(1'b1, 1'b1, 1'b1);
    chk("confirm_in_prep_state", 32'(game_state_code), 32'd1);
    exp_q.delete();
    press_start();
    chk_state("attack", 2'b10, 4'd12, 4'd0, 1'b0, 1'b0);
    shoot(1'b1, 1'b1, 1'b1);
    shoot(1'b0, 1'b0, 1'b0);
    chk_state("after_dups", 2'b10, 4'd12, 4'd0, 1'b0, 1'b0);
    shoot(1'b1, 1'b1, 1'b0);
    shoot(1'b1, 1'b1, 1'b0);
    shoot(1'b1, 1'b0, 1'b0);
    chk_state("hhm", 2'b10, REF ? 4'd11 : 4'd9, 4'd2, 1'b0, 1'b0);
    press_start();
    chk("start_in_attack", 32'(game_state_code), 32'd2);
    shoot(1'b1, 1'b1, 1'b0);
    chk_state("win1", 2'b11, REF ? 4'd11 : 4'd8, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    confirm_n = 1'b0;
    repeat (4) @(negedge clk);
    confirm_n = 1'b1;
    chk_state("end_hold", 2'b11, REF ? 4'd11 : 4'd8, 4'd3, 1'b1, 1'b0);
    press_start();
    chk_state("back_idle", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);

    // Round 2: 12 misses -> lose; held confirm gives no repeats
    ship_total = 4'd5;
    press_start();
    press_start();
    for (int i = 0; i < 12; i++) shoot(1'b1, 1'b0, 1'b0);
    chk_state("lose", 2'b11, 4'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    confirm_n = 1'b0;
    repeat (20) @(negedge clk);
    confirm_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_state("lose_hold", 2'b11, 4'd0, 4'd0, 1'b0, 1'b1);
    press_start();

    // Round 3: last shot both sinks final ship and empties shots
    press_start();
    press_start();
    ns = REF ? 11 : 7;
    for (int i = 0; i < 4; i++) shoot(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < ns; i++) shoot(1'b1, 1'b0, 1'b0);
    chk_state("pre_final", 2'b10, 4'd1, 4'd4, 1'b0, 1'b0);
    shoot(1'b1, 1'b1, 1'b0);
    chk_state("final_win", 2'b11, REF ? 4'd1 : 4'd0, 4'd5, 1'b1, 1'b0);
    press_start();

    // Round 4: reset between press and strobe drops the shot
    press_start();
    press_start();
    shoot(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    coord_valid      = 1'b1;
    cell_is_ship     = 1'b1;
    cell_already_hit = 1'b0;
    confirm_n        = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    confirm_n = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_state("mid_reset", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("mid_reset_strobe", 32'(attack_strobe), 32'd0);

    // Round 5: no ships means immediate win
    ship_total = 4'd0;
    press_start();
    press_start();
    chk_state("zero_enter", 2'b10, 4'd12, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_state("zero_win", 2'b11, 4'd12, 4'd0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
